uart_chal_rx: RTL and testbench

//  UART receiver plus line parser for host-to-FPGA challenge injection. This is the reverse path of the
//  CSV stream the board sends to the PC. Accepts lines of the form "C,<N/4 hex digits>\n" and presents
//  the decoded challenge on a valid/ready interface to the PUF control FSM. Host-chosen challenges

---
 rtl/uart_chal_rx_if.sv | 11 +
 rtl/uart_chal_rx.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_uart_chal_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_chal_rx_if.sv
// Challenge hand-off bundle between the UART line parser (master) and the PUF control FSM (slave).
interface uart_chal_rx_if #(
  parameter int N = 64
) ();
  logic [N-1:0] chal_o;
  logic         chal_valid;
  logic         chal_ready;

  modport master (output chal_o, output chal_valid, input chal_ready);
  modport slave  (input chal_o, input chal_valid, output chal_ready);
endinterface

// File: rtl/uart_chal_rx.sv
// UART receiver and "C,<hex>\n" line parser that delivers host-chosen challenges over valid/ready.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_chal_rx #(
  parameter int N      = 64,
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx_i,
  uart_chal_rx_if.master   chal_if,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             parse_err,
  output logic             overrun
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS + 1);
  localparam int D        = N / 4;
  localparam int DW       = $clog2(D + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [DW-1:0] D_FULL    = DW'(D);

  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } bit_st_e;

  typedef enum logic [1:0] {
    P_C     = 2'd0,
    P_COMMA = 2'd1,
    P_HEX   = 2'd2,
    P_SKIP  = 2'd3
  } p_st_e;

  // Returns {is_hex_digit, nibble} for an ASCII byte.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) begin
      return {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      return {1'b1, b[3:0] + 4'd9};
    end else begin
      return 5'b0_0000;
    end
  endfunction

`ifdef UART_RX_PARITY_EN
  // High when data plus parity bit does not have an even number of ones.
  function automatic logic even_par_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  bit_st_e       bit_st_q, bit_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_stb_q, byte_stb_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
`endif
  p_st_e         p_st_q, p_st_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          line_good_q, line_good_d;
  logic          parse_err_q, parse_err_d;
  logic [N-1:0]  chal_q, chal_d;
  logic          chal_valid_q, chal_valid_d;
  logic          overrun_q, overrun_d;

  logic          rxs_s;
  logic          stop_ok_s;
  logic [4:0]    hex_s;

  assign rxs_s = sync2_q;

  // Next-state logic for the synchroniser, bit engine, line parser and challenge register.
  always_comb begin
    sync1_d      = uart_rx_i;
    sync2_d      = sync1_q;
    bit_st_d     = bit_st_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_stb_d   = 1'b0;
    frame_err_d  = 1'b0;
    p_st_d       = p_st_q;
    dcnt_d       = dcnt_q;
    acc_d        = acc_q;
    line_good_d  = 1'b0;
    parse_err_d  = 1'b0;
    chal_d       = chal_q;
    chal_valid_d = chal_valid_q;
    overrun_d    = 1'b0;
    hex_s        = hex_decode(byte_q);
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    stop_ok_s    = rxs_s && !par_bad_q;
`else
    stop_ok_s    = rxs_s;
`endif

    case (bit_st_q)
      S_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (!rxs_s) begin
          bit_st_d = S_START;
        end else begin
          bit_st_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = {CW{1'b0}};
          bit_idx_d = 3'd0;
          if (rxs_s) begin
            bit_st_d = S_IDLE;
          end else begin
            bit_st_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = {CW{1'b0}};
          shift_d   = {rxs_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            bit_st_d = S_PAR;
`else
            bit_st_d = S_STOP;
`endif
          end else begin
            bit_st_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = {CW{1'b0}};
          par_bad_d = even_par_bad(shift_q, rxs_s);
          bit_st_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d    = {CW{1'b0}};
          bit_st_d = S_IDLE;
          if (stop_ok_s) begin
            byte_stb_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        bit_st_d = S_IDLE;
        cnt_d    = {CW{1'b0}};
      end
    endcase

    rx_busy_d = (bit_st_d != S_IDLE);

    if (frame_err_q) begin
      p_st_d = P_SKIP;
    end else if (byte_stb_q && (byte_q != CH_CR)) begin
      case (p_st_q)
        P_C: begin
          if (byte_q == CH_C) begin
            p_st_d = P_COMMA;
          end else if (byte_q == CH_LF) begin
            p_st_d = P_C;
          end else begin
            parse_err_d = 1'b1;
            p_st_d      = P_SKIP;
          end
        end
        P_COMMA: begin
          if (byte_q == CH_COMMA) begin
            p_st_d = P_HEX;
            dcnt_d = {DW{1'b0}};
            acc_d  = {N{1'b0}};
          end else if (byte_q == CH_LF) begin
            parse_err_d = 1'b1;
            p_st_d      = P_C;
          end else begin
            parse_err_d = 1'b1;
            p_st_d      = P_SKIP;
          end
        end
        P_HEX: begin
          if (hex_s[4]) begin
            if (dcnt_q == D_FULL) begin
              parse_err_d = 1'b1;
              p_st_d      = P_SKIP;
            end else begin
              acc_d  = {acc_q[N-5:0], hex_s[3:0]};
              dcnt_d = dcnt_q + DW'(1);
            end
          end else if (byte_q == CH_LF) begin
            p_st_d = P_C;
            if (dcnt_q == D_FULL) begin
              line_good_d = 1'b1;
            end else begin
              parse_err_d = 1'b1;
            end
          end else begin
            parse_err_d = 1'b1;
            p_st_d      = P_SKIP;
          end
        end
        P_SKIP: begin
          if (byte_q == CH_LF) begin
            p_st_d = P_C;
          end else begin
            p_st_d = P_SKIP;
          end
        end
        default: begin
          p_st_d = P_C;
        end
      endcase
    end else begin
      p_st_d = p_st_q;
    end

    // A load in the same clk as a consuming handshake takes precedence and is not an overrun.
    if (line_good_q && (!chal_valid_q || chal_if.chal_ready)) begin
      chal_d       = acc_q;
      chal_valid_d = 1'b1;
    end else if (line_good_q) begin
      overrun_d = 1'b1;
    end else if (chal_valid_q && chal_if.chal_ready) begin
      chal_valid_d = 1'b0;
    end else begin
      chal_valid_d = chal_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      bit_st_q     <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_q       <= 8'h00;
      byte_stb_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
      p_st_q       <= P_C;
      dcnt_q       <= {DW{1'b0}};
      acc_q        <= {N{1'b0}};
      line_good_q  <= 1'b0;
      parse_err_q  <= 1'b0;
      chal_q       <= {N{1'b0}};
      chal_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      bit_st_q     <= bit_st_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_stb_q   <= byte_stb_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
`endif
      p_st_q       <= p_st_d;
      dcnt_q       <= dcnt_d;
      acc_q        <= acc_d;
      line_good_q  <= line_good_d;
      parse_err_q  <= parse_err_d;
      chal_q       <= chal_d;
      chal_valid_q <= chal_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign chal_if.chal_o     = chal_q;
  assign chal_if.chal_valid = chal_valid_q;
  assign rx_busy            = rx_busy_q;
  assign frame_err          = frame_err_q;
  assign parse_err          = parse_err_q;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_uart_chal_rx.sv
// Bench for uart_chal_rx: line table plus hand-written corner sequences, scoreboard on the handshake.
module tb_uart_chal_rx;

  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx_busy, frame_err, parse_err, overrun;

  uart_chal_rx_if #(.N(64)) cif ();

  uart_chal_rx #(.N(64), .CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx_i (rx),
    .chal_if   (cif),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parse_err (parse_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  typedef struct packed {
    logic [191:0] txt;
    logic         good;
    logic [63:0]  chal;
    logic [3:0]   perr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse counters and scoreboard pop on each consumed challenge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_ferr++;
    if (parse_err === 1'b1) n_perr++;
    if (overrun === 1'b1) n_ovr++;
    if (cif.chal_valid === 1'b1 && cif.chal_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got chal_o %h expected no handshake", cif.chal_o);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_chal_o", cif.chal_o, sb_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BIT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
  endtask

  task automatic send_line(input logic [191:0] txt);
    int len;
    len = 0;
    for (int i = 0; i < 24; i++) if (txt[8*i +: 8] != 8'h00) len = i + 1;
    for (int i = len - 1; i >= 0; i--) send_byte(txt[8*i +: 8], 1'b1);
  endtask

  task automatic clear_counts();
    n_ferr = 0;
    n_perr = 0;
    n_ovr  = 0;
  endtask

  task automatic handshake(input string name);
    cif.chal_ready = 1'b1;
    tick(1);
    cif.chal_ready = 1'b0;
    check(name, {63'd0, cif.chal_valid}, 64'd0);
  endtask

  initial begin
    cif.chal_ready = 1'b0;
    vecs[0] = '{192'("C,0123456789ABCDEF\n"),   1'b1, 64'h0123456789ABCDEF, 4'd0};
    vecs[1] = '{192'("C,deadbeefcafef00d\r\n"), 1'b1, 64'hDEADBEEFCAFEF00D, 4'd0};
    vecs[2] = '{192'("\n"),                     1'b0, 64'h0,                4'd0};
    vecs[3] = '{192'("C,123\n"),                1'b0, 64'h0,                4'd1};
    vecs[4] = '{192'("C,0123456789ABCDEF0\n"),  1'b0, 64'h0,                4'd1};
    vecs[5] = '{192'("X,00\n"),                 1'b0, 64'h0,                4'd1};
    vecs[6] = '{192'("C,00000000000000FF\n"),   1'b1, 64'h00000000000000FF, 4'd0};
    vecs[7] = '{192'("C\n"),                    1'b0, 64'h0,                4'd1};
    vecs[8] = '{192'("C,0123456789ABCDEg\n"),   1'b0, 64'h0,                4'd1};

    tick(3);
    check("rst_chal_o", cif.chal_o, 64'd0);
    check("rst_valid", {63'd0, cif.chal_valid}, 64'd0);
    check("rst_busy", {63'd0, rx_busy}, 64'd0);
    check("rst_pulses", {61'd0, frame_err, parse_err, overrun}, 64'd0);
    rst = 1'b0;
    tick(5);

    for (int v = 0; v < 9; v++) begin
      clear_counts();
      if (vecs[v].good) sb_q.push_back(vecs[v].chal);
      send_line(vecs[v].txt);
      tick(20);
      check($sformatf("v%0d_perr", v), 64'(n_perr), 64'(vecs[v].perr));
      check($sformatf("v%0d_ferr", v), 64'(n_ferr), 64'd0);
      check($sformatf("v%0d_valid", v), {63'd0, cif.chal_valid}, {63'd0, vecs[v].good});
      if (vecs[v].good && cif.chal_valid) begin
        tick(100);
        check($sformatf("v%0d_held", v), {63'd0, cif.chal_valid}, 64'd1);
        handshake($sformatf("v%0d_clear", v));
      end
    end

    // Short low glitch must not start a frame.
    clear_counts();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch_busy", {63'd0, rx_busy}, 64'd0);
    check("glitch_errs", 64'(n_ferr + n_perr), 64'd0);
    check("glitch_valid", {63'd0, cif.chal_valid}, 64'd0);

    // Bad stop bit mid-line: frame error, remainder skipped.
    clear_counts();
    send_byte(8'h43, 1'b1);
    send_byte(8'h2C, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h32, 1'b0);
    rx = 1'b1;
    tick(20);
    send_line(192'("3\n"));
    tick(20);
    check("frm_ferr", 64'(n_ferr), 64'd1);
    check("frm_perr", 64'(n_perr), 64'd0);
    check("frm_valid", {63'd0, cif.chal_valid}, 64'd0);
    sb_q.push_back(64'hA5A5A5A5A5A5A5A5);
    send_line(192'("C,A5A5A5A5A5A5A5A5\n"));
    tick(20);
    check("frm_recover_valid", {63'd0, cif.chal_valid}, 64'd1);
    handshake("frm_recover_clear");

    // Second good line while the first is unconsumed: overrun, first retained.
    clear_counts();
    sb_q.push_back(64'h1111111111111111);
    send_line(192'("C,1111111111111111\n"));
    send_line(192'("C,3333333333333333\n"));
    tick(20);
    check("ovr_count", 64'(n_ovr), 64'd1);
    check("ovr_perr", 64'(n_perr), 64'd0);
    check("ovr_valid", {63'd0, cif.chal_valid}, 64'd1);
    handshake("ovr_clear");

    // Reset during data bit 4 of a partial line.
    clear_counts();
    send_line(192'("C,2222222222222222\n"));
    tick(20);
    check("rst2_pre_valid", {63'd0, cif.chal_valid}, 64'd1);
    send_byte(8'h43, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2_chal_o", cif.chal_o, 64'd0);
    check("rst2_valid", {63'd0, cif.chal_valid}, 64'd0);
    check("rst2_busy", {63'd0, rx_busy}, 64'd0);
    check("rst2_pulses", {61'd0, frame_err, parse_err, overrun}, 64'd0);
    tick(50);
    clear_counts();
    sb_q.push_back(64'hFEDCBA9876543210);
    send_line(192'("C,FEDCBA9876543210\n"));
    tick(20);
    check("rst2_after_valid", {63'd0, cif.chal_valid}, 64'd1);
    check("rst2_after_perr", 64'(n_perr), 64'd0);
    handshake("rst2_after_clear");

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: frame error, line dropped.
    clear_counts();
    send_byte(8'h43, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_line(192'(",0123456789ABCDEF\n"));
    tick(20);
    check("par_ferr", 64'(n_ferr), 64'd1);
    check("par_valid", {63'd0, cif.chal_valid}, 64'd0);
`endif

    tick(5);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
